mux_sync: RTL and testbench



---
 rtl/mux_sync_pkg.sv | 13 +
 rtl/mux_sync_sync_ff_chain.sv | 24 ++
 rtl/mux_sync.sv | 67 ++++++
 tb/tb_mux_sync.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_sync_pkg.sv
// Shared constants and checks for the mux-based CDC receive block.
// Used by mux_sync and its request synchronizer.
package mux_sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int DATA_WIDTH_DEF  = 12;

  // True when a synchronizer depth is deep enough to settle metastability.
  function automatic bit sync_stages_ok(input int stages);
    return stages >= SYNC_STAGES_MIN;
  endfunction

endpackage

// File: rtl/mux_sync_sync_ff_chain.sv
// Single-bit asynchronous-reset flop chain used as a metastability synchronizer.
// The chain registers are attributed so tools keep them adjacent and untouched.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/mux_sync.sv
// Receive side of a mux-based CDC synchronizer: the synchronized request rise loads wr_data.
// Optional feature macro: MUX_SYNC_ACK_EN adds rd_ack (synchronized request level).
module mux_sync
  import mux_sync_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  rd_clk,
  input  logic                  rd_reset,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
`ifdef MUX_SYNC_ACK_EN
  ,
  output logic                  rd_ack
`endif
);

  typedef logic [DATA_WIDTH-1:0] data_t;

  if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_stages
    $error("mux_sync: SYNC_STAGES must be >= %0d", SYNC_STAGES_MIN);
  end

  logic  w_req_s;
  logic  w_load;
  logic  r_req_d;
  data_t r_data;
  logic  r_valid;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .i_clk   (rd_clk),
    .i_rst_n (rd_reset),
    .i_d     (wr_req),
    .o_q     (w_req_s)
  );

  // Only the rising edge of the settled request opens the load mux; the bus
  // itself is sampled directly since the sender holds it stable meanwhile.
  assign w_load = w_req_s & ~r_req_d;

  always_ff @(posedge rd_clk or negedge rd_reset) begin
    if (!rd_reset) begin
      r_req_d <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_req_d <= w_req_s;
      r_valid <= w_load;
      if (w_load) begin
        r_data <= wr_data;
      end
    end
  end

  assign rd_data  = r_data;
  assign rd_valid = r_valid;

`ifdef MUX_SYNC_ACK_EN
  assign rd_ack = w_req_s;
`endif

endmodule

// File: tb/tb_mux_sync.sv
// Self-checking bench for mux_sync: directed scenarios plus randomized requests
// compared against a sample-history reference model.
module tb_mux_sync;

  localparam int DW = 12;
  localparam int S  = 2;

  logic          rd_clk   = 1'b0;
  logic          src_clk  = 1'b0;
  logic          rd_reset = 1'b0;
  logic          wr_req   = 1'b1;
  logic [DW-1:0] wr_data  = 12'hABC;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
`ifdef MUX_SYNC_ACK_EN
  logic          rd_ack;
`endif

  int n_chk   = 0;
  int n_pass  = 0;
  int cnt_valid = 0;

  mux_sync #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (S)
  ) dut (
    .rd_clk   (rd_clk),
    .rd_reset (rd_reset),
    .wr_req   (wr_req),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
`ifdef MUX_SYNC_ACK_EN
    ,
    .rd_ack   (rd_ack)
`endif
  );

  // rd_clk 40 ns; source clock 20 ns, offset so its edges never meet rd_clk edges
  initial forever #20 rd_clk = ~rd_clk;
  initial begin
    #5;
    forever begin
      src_clk = 1'b1; #10;
      src_clk = 1'b0; #10;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic src(input int n);
    repeat (n) @(posedge src_clk);
  endtask

  // Reference model: history of wr_req samples taken at each rd_clk edge.
  // A load at edge n happens when the sample S edges back is 1 and the one
  // before it is 0; the acknowledge shows the sample S-1 edges back.
  bit            hist[$];
  logic [DW-1:0] m_data  = '0;
  logic          m_valid = 1'b0;
  logic          m_ack   = 1'b0;

  function automatic bit samp(input int back);
    if (back >= hist.size()) return 1'b0;
    return hist[hist.size() - 1 - back];
  endfunction

  always @(posedge rd_clk or negedge rd_reset) begin
    if (!rd_reset) begin
      hist.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ack   = 1'b0;
    end else begin
      hist.push_back(wr_req);
      if (hist.size() > S + 4) void'(hist.pop_front());
      m_valid = samp(S) && !samp(S + 1);
      m_ack   = samp(S - 1);
      if (m_valid) m_data = wr_data;
    end
  end

  always @(negedge rd_clk) begin
    if (rd_valid === 1'b1) cnt_valid++;
    chk("model_data", 32'(rd_data), 32'(m_data));
    chk("model_valid", 32'(rd_valid), 32'(m_valid));
`ifdef MUX_SYNC_ACK_EN
    chk("model_ack", 32'(rd_ack), 32'(m_ack));
`endif
  end

  assert property (@(posedge rd_clk) disable iff (!rd_reset) rd_valid |-> rd_data == $past(wr_data))
  else begin
    n_chk++;
    $error("FAIL valid_data: observed %h expected %h", rd_data, $past(wr_data));
  end

  initial begin
    int            c0;
    bit            found;
    logic [31:0]   rnd;
    logic [DW-1:0] d;
    int            hi;

    // 1: reset held with a request pending
    repeat (2) begin
      @(negedge rd_clk);
      chk("t1_rst_data", 32'(rd_data), 32'h0);
      chk("t1_rst_valid", 32'(rd_valid), 32'h0);
`ifdef MUX_SYNC_ACK_EN
      chk("t1_rst_ack", 32'(rd_ack), 32'h0);
`endif
    end
    @(posedge src_clk);
    rd_reset = 1'b1;
    src(8);
    wr_req = 1'b0;
    src(8);
    chk("t1_release_capture", 32'(rd_data), 32'hABC);
    chk("t1_valid_count", 32'(cnt_valid), 32'd1);

    // 2: single request, exact latency
    c0 = cnt_valid;
    @(posedge src_clk);
    wr_data = 12'h5A3;
    @(posedge src_clk);
    wr_req = 1'b1;
    @(posedge rd_clk);
    @(posedge rd_clk);
    @(posedge src_clk);
    wr_req = 1'b0;
    @(negedge rd_clk);
    chk("t2_before_load", 32'(rd_data), 32'hABC);
    chk("t2_no_early_valid", 32'(rd_valid), 32'h0);
    @(negedge rd_clk);
    chk("t2_loaded", 32'(rd_data), 32'h5A3);
    chk("t2_valid_high", 32'(rd_valid), 32'h1);
    @(negedge rd_clk);
    chk("t2_valid_pulse_end", 32'(rd_valid), 32'h0);
    src(6);
    chk("t2_valid_count", 32'(cnt_valid - c0), 32'd1);

    // 3: long request loads once; later data change ignored
    c0 = cnt_valid;
    @(posedge src_clk);
    wr_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge rd_clk);
      if (rd_valid === 1'b1) found = 1'b1;
    end
    chk("t3_valid_seen", 32'(found), 32'h1);
    @(posedge src_clk);
    wr_data = 12'h111;
    src(14);
    wr_req = 1'b0;
    src(8);
    chk("t3_data_held", 32'(rd_data), 32'h5A3);
    chk("t3_single_valid", 32'(cnt_valid - c0), 32'd1);

    // 4: back-to-back minimum-spaced requests
    c0 = cnt_valid;
    for (int i = 1; i <= 3; i++) begin
      @(posedge src_clk);
      wr_data = DW'(i);
      @(posedge src_clk);
      wr_req = 1'b1;
      src(4);
      wr_req = 1'b0;
      src(6);
      chk("t4_step_data", 32'(rd_data), 32'(i));
    end
    chk("t4_valid_count", 32'(cnt_valid - c0), 32'd3);

    // 5: reset mid-transfer discards the request
    c0 = cnt_valid;
    @(posedge src_clk);
    wr_data = 12'hFFF;
    @(posedge src_clk);
    wr_req = 1'b1;
    @(posedge rd_clk);
    @(posedge src_clk);
    rd_reset = 1'b0;
    @(negedge rd_clk);
    chk("t5_async_clear", 32'(rd_data), 32'h0);
    @(posedge src_clk);
    rd_reset = 1'b1;
    wr_req   = 1'b0;
    src(10);
    chk("t5_data_zero", 32'(rd_data), 32'h0);
    chk("t5_no_valid", 32'(cnt_valid - c0), 32'd0);

`ifdef MUX_SYNC_ACK_EN
    // 6: acknowledge follows the request two edges late, both directions
    @(posedge src_clk);
    wr_data = 12'h3C3;
    @(posedge src_clk);
    wr_req = 1'b1;
    @(posedge rd_clk);
    @(negedge rd_clk);
    chk("t6_ack_low_k", 32'(rd_ack), 32'h0);
    @(negedge rd_clk);
    chk("t6_ack_high_k1", 32'(rd_ack), 32'h1);
    src(6);
    wr_req = 1'b0;
    @(posedge rd_clk);
    @(negedge rd_clk);
    chk("t6_ack_still_high", 32'(rd_ack), 32'h1);
    @(negedge rd_clk);
    chk("t6_ack_low", 32'(rd_ack), 32'h0);
    src(6);
`endif

    // Randomized requests honouring the source contract, with idle bus noise
    for (int r = 0; r < 24; r++) begin
      c0  = cnt_valid;
      rnd = $urandom;
      wr_data = rnd[DW-1:0];
      src(2);
      rnd = $urandom;
      d = rnd[DW-1:0];
      wr_data = d;
      src($urandom_range(1, 3));
      wr_req = 1'b1;
      hi = $urandom_range(2, 6);
      src(2 * hi + $urandom_range(0, 1));
      wr_req = 1'b0;
      src(8 + $urandom_range(0, 3));
      chk("rand_data", 32'(rd_data), 32'(d));
      chk("rand_valid_count", 32'(cnt_valid - c0), 32'd1);
    end

    src(4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
